// File: rtl/unidade_controle_mc_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_mc_pkg
//   Shared definitions for the multi-cycle control/decode stage and its
//   neighbours (ALU, fetch): instruction field positions, opcode constants,
//   ALU operation encodings, decode classes and the control FSM state type.
// -----------------------------------------------------------------------------
package unidade_controle_mc_pkg;

  // Default datapath geometry of the register bank this stage drives.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Instruction word layout: [15:12] opcode, [11:8] rc, [7:4] ra, [3:0] rb.
  // The immediate of LI overlays ra/rb as [7:0].
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RC_MSB  = 11;
  localparam int RC_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  // Opcodes. 9..E are undefined and flagged as illegal.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU select, always opcode - 1 for the ALU opcodes.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SHL = 3'd6
  } alu_op_t;

  // What the control FSM does after DECODE.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LI,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_HALTED
  } state_t;

  // Maps an ALU opcode (1..7) onto its ALU select.
  function automatic logic [2:0] alu_op_of(input logic [3:0] opc);
    logic [3:0] sel;
    sel = opc - 4'd1;
    return sel[2:0];
  endfunction

endpackage : unidade_controle_mc_pkg

// File: rtl/unidade_controle_mc_decodificador_instr.sv
// -----------------------------------------------------------------------------
// decodificador_instr
//   Purely combinational instruction decoder used by unidade_controle_mc.
//   Classifies the opcode held in the instruction register and extracts the
//   ALU select and the zero-extended immediate.
//
// Ports
//   opcode   in   4       opcode field of the instruction register
//   imm8     in   8       immediate field of the instruction register
//   cls      out  class   next-step class (NOP / ALU / LI / HALT / ILLEGAL)
//   alu_op   out  3       ALU select (opcode - 1), 0 for non-ALU opcodes
//   imm      out  DATA_W  immediate zero-extended to the datapath width
//   illegal  out  1       opcode is undefined (9..E)
// -----------------------------------------------------------------------------
module decodificador_instr
  import unidade_controle_mc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        opcode,
  input  logic [IMM_W-1:0]  imm8,
  output instr_class_t      cls,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);

  assign imm = {{(DATA_W - IMM_W){1'b0}}, imm8};

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    cls     = CLS_ILLEGAL;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_NOP:  cls = CLS_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SHL: begin
        cls    = CLS_ALU;
        alu_op = alu_op_of(opcode);
      end
      OP_LI:   cls = CLS_LI;
      OP_HALT: cls = CLS_HALT;
      default: begin
        cls     = CLS_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule : decodificador_instr

// File: rtl/unidade_controle_mc.sv
// -----------------------------------------------------------------------------
// unidade_controle_mc
//   Multi-cycle control/decode stage sitting directly in front of the 16x16
//   register bank. Takes one instruction at a time from fetch (valid/ready),
//   decodes it and drives the bank's read/write addresses, write enable and
//   write data. Write data is either the combinational ALU result (registered
//   in EXEC) or the zero-extended LI immediate. One instruction in flight.
//
//   Sequence per instruction:  IDLE -> DECODE -> [EXEC] -> [WRITE] -> IDLE
//     ALU ops : DECODE, EXEC, WRITE   (write in the 3rd cycle after accept)
//     LI      : DECODE, WRITE         (write in the 2nd cycle after accept)
//     NOP     : DECODE                (back in IDLE the 2nd cycle)
//     9..E    : DECODE, then IDLE with a one-cycle illegal pulse
//     HALT    : DECODE, then HALTED until reset
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   instr        in   16      instruction word
//   instr_valid  in   1       fetch presents instr
//   instr_ready  out  1       stage can accept instr (only in IDLE)
//   regA         out  ADDR_W  bank read address A
//   regB         out  ADDR_W  bank read address B
//   regC         out  ADDR_W  bank write address
//   RW           out  1       bank write enable, high for the WRITE cycle
//   dado         out  DATA_W  bank write data
//   alu_op       out  3       ALU operation select
//   alu_result   in   DATA_W  combinational ALU result from bank outputs A/B
//   halted       out  1       HALT has executed
//   illegal      out  1       one-cycle pulse on an undefined opcode
//   retired_cnt  out  16      (only with UNIDADE_CONTROLE_PERF_EN) count of
//                             completed writes and NOPs, wraps at 0xFFFF
//
// Build option
//   UNIDADE_CONTROLE_PERF_EN : adds the retired_cnt port and counter.
// -----------------------------------------------------------------------------
module unidade_controle_mc
  import unidade_controle_mc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] regA,
  output logic [ADDR_W-1:0] regB,
  output logic [ADDR_W-1:0] regC,
  output logic              RW,
  output logic [DATA_W-1:0] dado,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              halted,
  output logic              illegal
`ifdef UNIDADE_CONTROLE_PERF_EN
  ,
  output logic [15:0]       retired_cnt
`endif
);

  state_t state;

  // Instruction register. The register-address fields are copied straight to
  // regA/regB/regC on accept, so only the opcode and immediate are kept here.
  logic [3:0]       ir_opc;
  logic [IMM_W-1:0] ir_imm;

  instr_class_t      dec_cls;
  logic [2:0]        dec_alu_op;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal;

  decodificador_instr #(
    .DATA_W (DATA_W)
  ) u_dec (
    .opcode  (ir_opc),
    .imm8    (ir_imm),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // Ready is the only unregistered output. Gating with rst_n keeps it low
  // while reset is held even though the state already reads IDLE.
  assign instr_ready = rst_n && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir_opc  <= '0;
      ir_imm  <= '0;
      regA    <= '0;
      regB    <= '0;
      regC    <= '0;
      RW      <= 1'b0;
      dado    <= '0;
      alu_op  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
`ifdef UNIDADE_CONTROLE_PERF_EN
      retired_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register updates
      // from the values sampled at this edge regardless of statement order.
      // RW and illegal are single-cycle strobes; they fall unless a branch
      // below raises them for the next cycle.
      RW      <= 1'b0;
      illegal <= 1'b0;

      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir_opc <= instr[OPC_MSB:OPC_LSB];
            ir_imm <= instr[IMM_MSB:IMM_LSB];
            // Addresses settle during DECODE and hold through WRITE, so the
            // level-sensitive bank never sees regC move while RW is high.
            regA   <= ADDR_W'(instr[RA_MSB:RA_LSB]);
            regB   <= ADDR_W'(instr[RB_MSB:RB_LSB]);
            regC   <= ADDR_W'(instr[RC_MSB:RC_LSB]);
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (dec_illegal) begin
            illegal <= 1'b1;
            state   <= S_IDLE;
          end else begin
            case (dec_cls)
              CLS_ALU: begin
                alu_op <= dec_alu_op;
                state  <= S_EXEC;
              end
              CLS_LI: begin
                dado  <= dec_imm;
                RW    <= 1'b1;
                state <= S_WRITE;
              end
              CLS_HALT: begin
                halted <= 1'b1;
                state  <= S_HALTED;
              end
              default: begin
                // NOP retires immediately without touching the bank.
`ifdef UNIDADE_CONTROLE_PERF_EN
                retired_cnt <= retired_cnt + 16'd1;
`endif
                state <= S_IDLE;
              end
            endcase
          end
        end

        S_EXEC: begin
          // The bank outputs at regA/regB feed the ALU combinationally; the
          // result is frozen here so dado is stable for the whole WRITE cycle.
          dado  <= alu_result;
          RW    <= 1'b1;
          state <= S_WRITE;
        end

        S_WRITE: begin
`ifdef UNIDADE_CONTROLE_PERF_EN
          retired_cnt <= retired_cnt + 16'd1;
`endif
          state <= S_IDLE;
        end

        S_HALTED: begin
          state <= S_HALTED;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : unidade_controle_mc

// File: tb/tb_unidade_controle_mc.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_mc
//   Drives instructions into unidade_controle_mc, emulates the register bank
//   and a combinational ALU around it, and compares every bank write and
//   illegal pulse against a reference model of the instruction set.
// -----------------------------------------------------------------------------
module tb_unidade_controle_mc;
  import unidade_controle_mc_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam time PERIOD = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       instr = '0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [ADDR_W-1:0] regA, regB, regC;
  logic              RW;
  logic [DATA_W-1:0] dado;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              halted;
  logic              illegal;
`ifdef UNIDADE_CONTROLE_PERF_EN
  logic [15:0]       retired_cnt;
`endif

  unidade_controle_mc #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .regA        (regA),
    .regB        (regB),
    .regC        (regC),
    .RW          (RW),
    .dado        (dado),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .halted      (halted),
    .illegal     (illegal)
`ifdef UNIDADE_CONTROLE_PERF_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #(PERIOD / 2) clk = ~clk;

  // Instruction-set semantics by opcode.
  function automatic logic [15:0] alu_ref(input logic [3:0] opc,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    case (opc)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      OP_SHL:  return a << b[3:0];
      default: return 16'd0;
    endcase
  endfunction

  // Environment: level-sensitive bank written at the end of a RW cycle, and
  // an ALU selected by alu_op (opcode = alu_op + 1).
  logic [15:0] bank [16];
  always @(posedge clk) if (rst_n && RW) bank[regC] <= dado;
  assign alu_result = alu_ref({1'b0, alu_op} + 4'd1, bank[regA], bank[regB]);

  // Scoreboard.
  typedef struct {
    bit          is_illegal;
    logic [3:0]  addr;
    logic [15:0] data;
    bit          is_alu;
    logic [2:0]  aop;
    logic [3:0]  ra;
    logic [3:0]  rb;
    time         t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] ref_bank [16];
  int          ref_retired = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: predicts the observable effect of one accepted
  // instruction, given the negedge time at which valid was presented.
  task automatic model(input logic [15:0] w, input time t0);
    logic [3:0]  opc, rc, ra, rb;
    logic [15:0] res;
    exp_t        e;
    opc = w[15:12]; rc = w[11:8]; ra = w[7:4]; rb = w[3:0];
    e.is_illegal = 1'b0; e.addr = rc; e.data = '0; e.is_alu = 1'b0;
    e.aop = '0; e.ra = ra; e.rb = rb; e.t = t0;
    if (opc == OP_NOP) begin
      ref_retired++;
    end else if (opc >= OP_ADD && opc <= OP_SHL) begin
      res = alu_ref(opc, ref_bank[ra], ref_bank[rb]);
      e.data = res; e.is_alu = 1'b1; e.aop = 3'(opc - 4'd1);
      e.t = t0 + 3 * PERIOD;
      sb.push_back(e);
      ref_bank[rc] = res;
      ref_retired++;
    end else if (opc == OP_LI) begin
      e.data = {8'h00, w[7:0]};
      e.t = t0 + 2 * PERIOD;
      sb.push_back(e);
      ref_bank[rc] = e.data;
      ref_retired++;
    end else if (opc != OP_HALT) begin
      e.is_illegal = 1'b1;
      e.t = t0 + 2 * PERIOD;
      sb.push_back(e);
    end
  endtask

  // Monitor: every write strobe or illegal pulse must match the next
  // expected event, at the expected time.
  always @(negedge clk) begin
    if (rst_n && (RW || illegal)) begin
      if (sb.size() == 0) begin
        check(RW ? "unexpected_write" : "unexpected_illegal", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind_illegal", {31'd0, illegal}, {31'd0, mon_e.is_illegal});
        check("event_time", 32'($time), 32'(mon_e.t));
        if (mon_e.is_illegal) begin
          check("no_write_on_illegal", {31'd0, RW}, 32'd0);
          check("ready_after_illegal", {31'd0, instr_ready}, 32'd1);
        end else begin
          check("write_addr", {28'd0, regC}, {28'd0, mon_e.addr});
          check("write_data", {16'd0, dado}, {16'd0, mon_e.data});
          if (mon_e.is_alu) begin
            check("alu_op", {29'd0, alu_op}, {29'd0, mon_e.aop});
            check("read_addrs", {24'd0, regA, regB}, {24'd0, mon_e.ra, mon_e.rb});
          end
        end
      end
    end
  end

  // Presents one instruction as soon as the stage is ready.
  task automatic issue(input logic [15:0] w, input bit predict);
    int k;
    @(negedge clk);
    k = 0;
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      instr       = w;
      instr_valid = 1'b1;
      if (predict) model(w, $time);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain_to_idle", {31'd0, instr_ready}, 32'd1);
  endtask

  logic [15:0] directed [12];
  bit          ever_ready;
  logic [3:0]  r_opc;

  initial begin
    for (int i = 0; i < 16; i++) ref_bank[i] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {8'd0, instr_ready, RW, halted, illegal, regA, regB, regC, alu_op, 1'b0},
          32'd0);
    check("reset_dado", {16'd0, dado}, 32'd0);
    rst_n = 1'b1;
    #1 check("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    // Reset mid-EXEC of ADD r4,r1,r2: the write must never happen.
    @(negedge clk);
    instr = 16'h1412; instr_valid = 1'b1;
    @(negedge clk);                  // DECODE
    instr_valid = 1'b0;
    @(negedge clk);                  // EXEC
    rst_n = 1'b0;
    #1 check("abort_outputs_zero",
             {8'd0, instr_ready, RW, halted, illegal, regA, regB, regC, alu_op, 1'b0},
             32'd0);
    check("abort_dado_zero", {16'd0, dado}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_retired = 0;
    #1 check("ready_after_abort", {31'd0, instr_ready}, 32'd1);

    // Load every register with a random value.
    for (int r = 0; r < 16; r++) issue({OP_LI, 4'(r), 8'($urandom)}, 1'b1);

    // Directed cases: LI, ADD 7+9, SUB wrap, signed SLT, illegal, NOP.
    directed = '{16'h835A, 16'h8107, 16'h8209, 16'h1412,
                 16'h8100, 16'h8201, 16'h2512,
                 16'h8180, 16'h8208, 16'h7112,
                 16'hA123, 16'h0000};
    for (int i = 0; i < 12; i++) issue(directed[i], 1'b1);
    // 0x8000 < 0x0001 signed, with rc aliasing a source register.
    issue(16'h8201, 1'b1);
    issue(16'h6112, 1'b1);

    // Random instruction stream (everything except HALT).
    for (int i = 0; i < 300; i++) begin
      r_opc = 4'($urandom_range(0, 14));
      issue({r_opc, 12'($urandom)}, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    @(negedge clk);
`ifdef UNIDADE_CONTROLE_PERF_EN
    check("retired_cnt", {16'd0, retired_cnt}, {16'd0, 16'(ref_retired)});
`endif

    // HALT: stays halted and never ready again, even with valid held high.
    issue(16'hF000, 1'b1);
    @(negedge clk);
    check("halted_set", {31'd0, halted}, 32'd1);
    instr = 16'h8FFF; instr_valid = 1'b1;
    ever_ready = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (instr_ready || RW) ever_ready = 1'b1;
    end
    instr_valid = 1'b0;
    check("halted_blocks_fetch", {31'd0, ever_ready}, 32'd0);
    check("halted_held", {31'd0, halted}, 32'd1);
`ifdef UNIDADE_CONTROLE_PERF_EN
    check("retired_cnt_after_halt", {16'd0, retired_cnt}, {16'd0, 16'(ref_retired)});
`endif
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_unidade_controle_mc

// File: doc/unidade_controle_mc.md
Name: unidade_controle_mc

Overview:
- Multi-cycle control/decode stage directly upstream of the 16x16 register bank.
- Accepts one 16-bit instruction at a time from fetch via valid/ready and decodes it.
- Drives the bank's read addresses, write address, write enable and write data; data comes from the combinational ALU result or an immediate.
- One instruction in flight; no pipelining.

Parameters:
- DATA_W, 16, datapath/register width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  16  instruction word. Fields: [15:12] opcode, [11:8] rc, [7:4] ra, [3:0] rb; imm = [7:0].
- instr_valid  in  1  fetch presents instr.
- instr_ready  out  1  block can accept instr.
- regA  out  ADDR_W  read address A to register bank.
- regB  out  ADDR_W  read address B to register bank.
- regC  out  ADDR_W  write address to register bank.
- RW  out  1  bank write enable (1 = write).
- dado  out  DATA_W  write data to register bank.
- alu_op  out  3  ALU operation select.
- alu_result  in  DATA_W  combinational ALU result from bank outputs A/B.
- halted  out  1  HALT executed.
- illegal  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset: all outputs 0 (instr_ready=0, RW=0, halted=0, illegal=0). State=IDLE; IR and result register cleared. Reset is asynchronous; asserting it mid-instruction aborts it with no write, and RW drops immediately.
- States: IDLE, DECODE, EXEC, WRITE, HALTED. All outputs are registered except instr_ready, which is 1 exactly in IDLE.
- IDLE: on instr_valid && instr_ready, capture instr into IR and go to DECODE. Without valid, stay in IDLE.
- DECODE: regA=IR.ra, regB=IR.rb, regC=IR.rc. These hold until the next DECODE.
  - Opcodes 1-7 go to EXEC.
  - 8 (LI) goes to WRITE with dado = zero-extended imm.
  - 0 (NOP) goes to IDLE.
  - F (HALT) goes to HALTED.
  - 9-E: pulse illegal for one cycle, go to IDLE, no write.
- ALU opcode map: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed), 7 SHL. alu_op = opcode-1, set on DECODE exit.
- EXEC: register alu_result into dado; go to WRITE. Add/sub wrap modulo 2^DATA_W; no flags.
- WRITE: RW=1 for exactly this one cycle. regC and dado are stable from the previous cycle through the end of WRITE, because the bank is level-sensitive. Then go to IDLE and drop RW.
- Latency, accept to write cycle: ALU instructions 3 cycles (DECODE, EXEC, WRITE); LI 2 cycles; NOP 1 cycle back to IDLE.
- HALTED: halted=1, instr_ready=0, RW=0. Only reset exits.
- rc=0 is a normal writable register (no hardwired zero).
- ra/rb equal to rc is legal: reads complete in DECODE/EXEC, before the write.
- instr_valid is ignored outside IDLE; fetch must hold instr until accepted.

Optional Feature:
- Macro UNIDADE_CONTROLE_PERF_EN.
- Defined: adds output port retired_cnt [15:0]. It increments by 1 on every completed WRITE cycle and every NOP, wraps at 0xFFFF→0, resets to 0, and does not count illegal opcodes or HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: opcode constants (OP_NOP..OP_HALT), alu_op encodings, state encoding typedef, field-slice bit positions. The ALU and fetch blocks reuse these.
- One sub-module is natural: decodificador_instr, combinational, IR → {next-state class, alu_op, imm, illegal}. The FSM and registers stay in the top module.

Test Plan:
- Reset mid-EXEC of ADD (rst_n low 1 cycle) → RW never asserted; all outputs 0; IDLE with instr_ready=1 after release.
- LI r3,0x5A (0x835A) → RW=1 one cycle, 2 cycles after accept, regC=3, dado=0x005A.
- With bank r1=7, r2=9, ADD r4,r1,r2 (0x1412) and ALU model → regA=1, regB=2, alu_op=0, write cycle 3 cycles after accept: regC=4, dado=0x0010.
- SUB wrap: r1=0, r2=1, SUB r5,r1,r2 (0x2512) → dado=0xFFFF. SLT signed: 0x8000<0x0001 → dado=0x0001.
- Opcode 0xA (0xA123) → illegal pulses once, no RW, instr_ready back next cycle. HALT (0xF000) → halted=1, instr_ready stays 0 for 100 cycles despite instr_valid=1.
- With UNIDADE_CONTROLE_PERF_EN: LI, NOP, illegal, ADD → retired_cnt=3. Preload the counter near wrap → rolls 0xFFFF→0.
